sc_io_port: RTL

- Memory-mapped I/O responder on the sc_computer data-memory bus.
- Services CPU word reads and writes in the I/O window, selected when addr[7]=1 upstream.
- Conditions board inputs: two-flop synchroniser, debounce, and sticky key-press capture.
- Drives four active-low seven-segment digits from a hex value register, or from a raw segment register.

---
 rtl/sc_io_port_if.sv | 15 +
 rtl/sc_io_port.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sc_io_port_if.sv
// CPU data-memory bus slice seen by the I/O window responder.
// Latency: none, this is just the bundle of signals.
// Backpressure: none, the responder accepts every access in the cycle it is presented.
interface sc_io_port_if;
  logic [4:0]  addr;
  logic [31:0] datain;
  logic        we;
  logic [31:0] dataout;

  // CPU side drives address/data/strobe and samples the read mux.
  modport master (output addr, output datain, output we, input dataout);

  // Responder side.
  modport slave (input addr, input datain, input we, output dataout);
endinterface

// File: rtl/sc_io_port.sv
// Memory-mapped I/O responder: conditioned switches/keys in, four seven-segment digits out.
// Latency: reads combinational; writes land at the clock edge; io_out one cycle after its source register.
// Backpressure: none, every bus access completes in its own cycle.
module sc_io_port #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic         clock,
  input  logic         reset,
  sc_io_port_if.slave  bus,
  input  logic [9:0]   io_in,
  output logic [27:0]  io_out
);

  // Key bits idle high (released) so leaving reset never looks like a press.
  localparam logic [9:0]       IN_RST   = 10'h300;
  localparam logic [27:0]      OUT_RST  = 28'h8102040;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [4:0] A_DEB  = 5'd0;
  localparam logic [4:0] A_EVT  = 5'd1;
  localparam logic [4:0] A_HEX  = 5'd2;
  localparam logic [4:0] A_MODE = 5'd3;
  localparam logic [4:0] A_RAW  = 5'd4;

  logic [9:0]       sync_a;
  logic [9:0]       sync_q;
  logic [9:0]       deb;
  logic [9:0]       deb_nxt;
  logic [CNT_W-1:0] cnt     [10];
  logic [CNT_W-1:0] cnt_nxt [10];
  logic [1:0]       key_evt;
  logic [1:0]       key_fall;
  logic [1:0]       w1c;
  logic [15:0]      hex_val;
  logic             raw_mode;
  logic [27:0]      raw_seg;
  logic [27:0]      hex_disp;
  logic             unused_hi;

  // Top nibble of the write data has no destination in any register.
  assign unused_hi = ^bus.datain[31:28];

  // Active-low g..a pattern for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Two-flop synchroniser for the asynchronous board inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= IN_RST;
      sync_q <= IN_RST;
    end else begin
      sync_a <= io_in;
      sync_q <= sync_a;
    end
  end

  // Per-bit debounce: count consecutive disagreeing cycles, adopt sync after DEBOUNCE_CYCLES of them.
  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < 10; i++) begin
      cnt_nxt[i] = '0;
      if (sync_q[i] != deb[i]) begin
        if (cnt[i] == CNT_LAST) begin
          deb_nxt[i] = sync_q[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb <= IN_RST;
      for (int i = 0; i < 10; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      deb <= deb_nxt;
      for (int i = 0; i < 10; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Press = debounced key going high->low on this edge; W1C mask from a write to the event register.
  always_comb begin
    key_fall = deb[9:8] & ~deb_nxt[9:8];
    w1c      = (bus.we && bus.addr == A_EVT) ? bus.datain[1:0] : 2'b00;
  end

  // Sticky key events; a press in the same cycle as its clear keeps the bit set.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_evt <= 2'b00;
    end else begin
      key_evt <= (key_evt & ~w1c) | key_fall;
    end
  end

  // CPU-writable display registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      hex_val  <= '0;
      raw_mode <= 1'b0;
      raw_seg  <= '0;
    end else if (bus.we) begin
      case (bus.addr)
        A_HEX:   hex_val  <= bus.datain[15:0];
        A_MODE:  raw_mode <= bus.datain[0];
        A_RAW:   raw_seg  <= bus.datain[27:0];
        default: ;
      endcase
    end
  end

  // Hex value decoded into four digits, digit 0 in the low bits.
  always_comb begin
    hex_disp = {seg7(hex_val[15:12]), seg7(hex_val[11:8]),
                seg7(hex_val[7:4]),   seg7(hex_val[3:0])};
  end

  // Registered segment drive, chosen between decoded hex and raw pattern.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_out <= OUT_RST;
    end else begin
      io_out <= raw_mode ? raw_seg : hex_disp;
    end
  end

  // Zero-latency read mux; reads have no side effects.
  always_comb begin
    bus.dataout = '0;
    case (bus.addr)
      A_DEB:   bus.dataout = {22'b0, deb};
      A_EVT:   bus.dataout = {30'b0, key_evt};
      A_HEX:   bus.dataout = {16'b0, hex_val};
      A_MODE:  bus.dataout = {31'b0, raw_mode};
      A_RAW:   bus.dataout = {4'b0, raw_seg};
      default: bus.dataout = '0;
    endcase
  end

endmodule
